// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter.
package dmem_pkg;

  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_ADDR_W = 10;
  localparam int unsigned REQ_ADDR_W  = 32;
  localparam int unsigned STAT_W      = 32;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the port that did not win last time wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Grant A if alone or if B won last; otherwise grant B when it asks.
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port synchronous-read data memory between core (A) and DMA/debug (B).
// Optional per-port grant and conflict counters under DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned ADDR_W = DMEM_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  input  logic                  a_we,
  input  logic [REQ_ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  output logic                  a_ready,
  output logic                  a_rvalid,
  output logic [DATA_W-1:0]     a_rdata,
  input  logic                  b_valid,
  input  logic                  b_we,
  input  logic [REQ_ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0]     b_wdata,
  output logic                  b_ready,
  output logic                  b_rvalid,
  output logic [DATA_W-1:0]     b_rdata,
`ifdef DMEM_ARB_STATS_EN
  output logic [STAT_W-1:0]     a_grant_cnt,
  output logic [STAT_W-1:0]     b_grant_cnt,
  output logic [STAT_W-1:0]     conflict_cnt,
`endif
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [REQ_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  logic [1:0]            req;
  logic [1:0]            gnt;
  logic                  gnt_any;
  logic                  sel_b;
  logic                  sel_we;
  logic [REQ_ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_wdata;

  logic last_grant_q, last_grant_d;
  logic rsp_pend_q, rsp_pend_d;
  logic rsp_id_q, rsp_id_d;

  // Address bits above the memory depth are intentionally ignored.
  logic addr_unused;
  assign addr_unused = ^{a_addr[REQ_ADDR_W-1:ADDR_W], b_addr[REQ_ADDR_W-1:ADDR_W]};

  // Requests are masked while in reset so no grant can leak out.
  always_comb begin
    req = {b_valid & rst_n, a_valid & rst_n};
  end

  rr_arb2 u_rr_arb2 (
    .req  (req),
    .last (last_grant_q),
    .gnt  (gnt)
  );

  // Select the granted request and drive ready and the memory interface.
  always_comb begin
    gnt_any   = |gnt;
    sel_b     = gnt[1];
    sel_we    = sel_b ? b_we    : a_we;
    sel_addr  = sel_b ? b_addr  : a_addr;
    sel_wdata = sel_b ? b_wdata : a_wdata;
    a_ready   = gnt[0];
    b_ready   = gnt[1];
    mem_we    = gnt_any & sel_we;
    mem_re    = gnt_any & ~sel_we;
    mem_addr  = gnt_any ? REQ_ADDR_W'(sel_addr[ADDR_W-1:0]) : '0;
    mem_wdata = gnt_any ? sel_wdata : '0;
  end

  // Next-state for grant history and the one-stage read response tracker.
  always_comb begin
    last_grant_d = last_grant_q;
    rsp_pend_d   = 1'b0;
    rsp_id_d     = PORT_A;
    if (gnt_any) begin
      last_grant_d = sel_b;
    end
    if (gnt_any && !sel_we) begin
      rsp_pend_d = 1'b1;
      rsp_id_d   = sel_b;
    end
  end

  // Route the memory read data back to whichever port issued the read.
  always_comb begin
    a_rvalid = rsp_pend_q && (rsp_id_q == PORT_A);
    b_rvalid = rsp_pend_q && (rsp_id_q == PORT_B);
    a_rdata  = a_rvalid ? mem_rdata : '0;
    b_rdata  = b_rvalid ? mem_rdata : '0;
  end

  // Arbitration and response state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= PORT_B;
      rsp_pend_q   <= 1'b0;
      rsp_id_q     <= PORT_A;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_pend_q   <= rsp_pend_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] a_grant_cnt_q, a_grant_cnt_d;
  logic [STAT_W-1:0] b_grant_cnt_q, b_grant_cnt_d;
  logic [STAT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  // Saturating counters for accepted transfers and contested cycles.
  always_comb begin
    a_grant_cnt_d  = a_grant_cnt_q;
    b_grant_cnt_d  = b_grant_cnt_q;
    conflict_cnt_d = conflict_cnt_q;
    if (gnt[0] && (a_grant_cnt_q != '1)) begin
      a_grant_cnt_d = a_grant_cnt_q + STAT_W'(1);
    end
    if (gnt[1] && (b_grant_cnt_q != '1)) begin
      b_grant_cnt_d = b_grant_cnt_q + STAT_W'(1);
    end
    if ((req == 2'b11) && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + STAT_W'(1);
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_grant_cnt_q  <= '0;
      b_grant_cnt_q  <= '0;
      conflict_cnt_q <= '0;
    end else begin
      a_grant_cnt_q  <= a_grant_cnt_d;
      b_grant_cnt_q  <= b_grant_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign a_grant_cnt  = a_grant_cnt_q;
  assign b_grant_cnt  = b_grant_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: memory model, reference arbiter model, scenario tasks.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_we, a_ready, a_rvalid;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_valid, b_we, b_ready, b_rvalid;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        mem_we, mem_re;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] a_grant_cnt, b_grant_cnt, conflict_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_ready   (a_ready),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_valid   (b_valid),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ready   (b_ready),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
`ifdef DMEM_ARB_STATS_EN
    .a_grant_cnt  (a_grant_cnt),
    .b_grant_cnt  (b_grant_cnt),
    .conflict_cnt (conflict_cnt),
`endif
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] init_val(input int a);
    if (a == 5) return 32'hDEAD_BEEF;
    return 32'h9E37_79B9 * 32'(a) + 32'h0000_1234;
  endfunction

  // Single-port synchronous-read memory.
  logic [31:0] mem [1024];
  bit          mem_wr [1024];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[9:0]]    <= mem_wdata;
      mem_wr[mem_addr[9:0]] <= 1'b1;
    end
    if (mem_re) mem_rdata <= mem_wr[mem_addr[9:0]] ? mem[mem_addr[9:0]] : init_val(int'(mem_addr[9:0]));
  end

  // Reference model state: word-level memory contents and arbiter history.
  logic [31:0] ref_mem [1024];
  bit          ref_wr [1024];
  int          m_last;
  bit          m_pend;
  int          m_id;
  logic [31:0] m_data;
  int          m_acnt, m_bcnt, m_ccnt;
  bit          last_ga, last_gb;

  function automatic logic [31:0] ref_read(input int a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  task automatic model_reset();
    m_last = 1; m_pend = 0; m_id = 0; m_data = '0;
    m_acnt = 0; m_bcnt = 0; m_ccnt = 0;
  endtask

  // One cycle: inputs already driven at negedge; compare, advance model, clear accepted requests.
  task automatic step();
    bit ga, gb, e_we, e_re, e_arv, e_brv;
    logic [31:0] e_addr, e_wd, e_ard, e_brd;
    int wa;
    #1;
    ga = a_valid && (!b_valid || m_last == 1);
    gb = b_valid && !ga;
    e_we = 0; e_re = 0; e_addr = 0; e_wd = 0;
    if (ga) begin e_we = a_we; e_re = !a_we; e_addr = a_addr % 1024; e_wd = a_wdata; end
    if (gb) begin e_we = b_we; e_re = !b_we; e_addr = b_addr % 1024; e_wd = b_wdata; end
    e_arv = m_pend && m_id == 0;
    e_brv = m_pend && m_id == 1;
    e_ard = e_arv ? m_data : 32'h0;
    e_brd = e_brv ? m_data : 32'h0;

    total++;
    if ({a_ready, b_ready} !== {ga, gb}) begin
      bad++; $display("FAIL ready: got a=%b b=%b want a=%b b=%b", a_ready, b_ready, ga, gb);
    end
    total++;
    if ({mem_we, mem_re} !== {e_we, e_re}) begin
      bad++; $display("FAIL mem_en: got we=%b re=%b want we=%b re=%b", mem_we, mem_re, e_we, e_re);
    end
    total++;
    if (mem_addr !== e_addr || mem_wdata !== e_wd) begin
      bad++; $display("FAIL mem_bus: got addr=%h wd=%h want addr=%h wd=%h", mem_addr, mem_wdata, e_addr, e_wd);
    end
    total++;
    if (a_rvalid !== e_arv || a_rdata !== e_ard) begin
      bad++; $display("FAIL a_rsp: got v=%b d=%h want v=%b d=%h", a_rvalid, a_rdata, e_arv, e_ard);
    end
    total++;
    if (b_rvalid !== e_brv || b_rdata !== e_brd) begin
      bad++; $display("FAIL b_rsp: got v=%b d=%h want v=%b d=%h", b_rvalid, b_rdata, e_brv, e_brd);
    end

    if (a_valid && b_valid) m_ccnt++;
    m_pend = 0; m_id = 0;
    if (ga || gb) begin
      m_last = gb ? 1 : 0;
      if (ga) m_acnt++; else m_bcnt++;
      wa = int'(e_addr);
      if (e_we) begin
        ref_mem[wa] = e_wd; ref_wr[wa] = 1;
      end else begin
        m_pend = 1; m_id = gb ? 1 : 0; m_data = ref_read(wa);
      end
    end
    last_ga = ga; last_gb = gb;
    @(posedge clk);
    @(negedge clk);
    if (ga) a_valid = 0;
    if (gb) b_valid = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; a_valid = 0; b_valid = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic set_a(input bit we, input logic [31:0] addr, input logic [31:0] wd);
    a_valid = 1; a_we = we; a_addr = addr; a_wdata = wd;
  endtask

  task automatic set_b(input bit we, input logic [31:0] addr, input logic [31:0] wd);
    b_valid = 1; b_we = we; b_addr = addr; b_wdata = wd;
  endtask

  task automatic test_reset();
    rst_n = 0;
    set_a(1, 32'h10, 32'h1111_1111);
    set_b(0, 32'h20, 32'h0);
    #1;
    total++;
    if ({a_ready, b_ready, mem_we, mem_re} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctl: got %b want 0000", {a_ready, b_ready, mem_we, mem_re});
    end
    total++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      bad++; $display("FAIL reset_bus: got addr=%h wd=%h want 0", mem_addr, mem_wdata);
    end
    total++;
    if ({a_rvalid, b_rvalid} !== 2'b00 || a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rsp: got v=%b ad=%h bd=%h want 0", {a_rvalid, b_rvalid}, a_rdata, b_rdata);
    end
`ifdef DMEM_ARB_STATS_EN
    total++;
    if ({a_grant_cnt, b_grant_cnt, conflict_cnt} !== 96'h0) begin
      bad++; $display("FAIL reset_stats: got %0d %0d %0d want 0 0 0", a_grant_cnt, b_grant_cnt, conflict_cnt);
    end
`endif
    do_reset();
  endtask

  task automatic test_first_read();
    do_reset();
    set_a(0, 32'd5, 32'h0);
    step();
    total++;
    if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEAD_BEEF || b_rvalid !== 1'b0) begin
      bad++; $display("FAIL first_read: got v=%b d=%h bv=%b want 1 deadbeef 0", a_rvalid, a_rdata, b_rvalid);
    end
    step();
  endtask

  task automatic test_contested();
    bit [3:0] ga_seq;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (!a_valid) set_a(i >= 2, 32'(100 + i), $urandom);
      if (!b_valid) set_b(i >= 2, 32'(200 + i), $urandom);
      step();
      ga_seq[i] = last_ga;
    end
    total++;
    if (ga_seq !== 4'b0101) begin
      bad++; $display("FAIL contested_order: got a-grant bits=%b want 0101", ga_seq);
    end
    a_valid = 0; b_valid = 0;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    set_b(1, 32'd7, 32'h1234_5678);
    step();
    set_b(0, 32'd7, 32'h0);
    step();
    total++;
    if (b_rvalid !== 1'b1 || b_rdata !== 32'h1234_5678) begin
      bad++; $display("FAIL raw_same_addr: got v=%b d=%h want 1 12345678", b_rvalid, b_rdata);
    end
    step();
  endtask

  task automatic test_addr_mask();
    set_a(0, 32'h0000_0C03, 32'h0);
    #1;
    total++;
    if (mem_addr !== 32'h0000_0003) begin
      bad++; $display("FAIL addr_mask: got %h want 00000003", mem_addr);
    end
    step();
    step();
  endtask

  task automatic test_reset_mid();
    set_a(0, 32'd9, 32'h0);
    step();
    total++;
    if (a_rvalid !== 1'b1) begin
      bad++; $display("FAIL mid_pre: got rvalid=%b want 1", a_rvalid);
    end
    set_a(0, 32'd11, 32'h0);
    rst_n = 0;
    #1;
    total++;
    if (a_rvalid !== 1'b0 || mem_re !== 1'b0 || a_ready !== 1'b0) begin
      bad++; $display("FAIL mid_reset: got rv=%b re=%b rdy=%b want 0 0 0", a_rvalid, mem_re, a_ready);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    a_valid = 0;
    rst_n = 1;
    step();
    step();
    set_a(0, 32'd1, 32'h0);
    set_b(0, 32'd2, 32'h0);
    step();
    total++;
    if (last_ga !== 1'b1 || last_gb !== 1'b0) begin
      bad++; $display("FAIL mid_first_grant: model/dut a=%b b=%b want a=1 b=0", last_ga, last_gb);
    end
    step();
    a_valid = 0; b_valid = 0;
    step();
  endtask

  task automatic test_random();
    logic [31:0] t;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (!a_valid && $urandom_range(0, 9) < 6) begin
        t = $urandom;
        set_a($urandom_range(0, 1) == 1, (t & 32'hFFFF_FC00) | 32'($urandom_range(0, 15)), $urandom);
      end
      if (!b_valid && $urandom_range(0, 9) < 6) begin
        t = $urandom;
        set_b($urandom_range(0, 1) == 1, (t & 32'hFFFF_FC00) | 32'($urandom_range(0, 15)), $urandom);
      end
      step();
    end
    a_valid = 0; b_valid = 0;
    step();
`ifdef DMEM_ARB_STATS_EN
    total++;
    if (a_grant_cnt !== 32'(m_acnt) || b_grant_cnt !== 32'(m_bcnt) || conflict_cnt !== 32'(m_ccnt)) begin
      bad++; $display("FAIL random_stats: got %0d %0d %0d want %0d %0d %0d",
                      a_grant_cnt, b_grant_cnt, conflict_cnt, m_acnt, m_bcnt, m_ccnt);
    end
`endif
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    total++;
    if ({a_grant_cnt, b_grant_cnt, conflict_cnt} !== 96'h0) begin
      bad++; $display("FAIL stats_reset: got %0d %0d %0d want 0 0 0", a_grant_cnt, b_grant_cnt, conflict_cnt);
    end
    set_a(0, 32'd1, 32'h0); set_b(0, 32'd2, 32'h0);
    step();
    set_a(1, 32'd3, 32'hA5A5_0001);
    step();
    step();
    set_a(0, 32'd4, 32'h0);
    step();
    set_b(1, 32'd6, 32'h5A5A_0002);
    step();
    step();
    total++;
    if (a_grant_cnt !== 32'd3 || b_grant_cnt !== 32'd2 || conflict_cnt !== 32'd2) begin
      bad++; $display("FAIL stats_counts: got %0d %0d %0d want 3 2 2", a_grant_cnt, b_grant_cnt, conflict_cnt);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    a_valid = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_valid = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_first_read();
    test_contested();
    test_back_to_back();
    test_addr_mask();
    test_reset_mid();
    test_random();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
